// File: rtl/pwm_multichan.sv
// -----------------------------------------------------------------------------
// pwm_multichan
//
// Multi-channel PWM generator. A shared prescaler and period counter drive
// CHANNELS duty comparators. PERIOD, PRESCALE, CTRL and DUTY[i] are written
// through a register-write port into shadow registers. The active PERIOD and
// DUTY copies reload from the shadows only at a frame boundary, so a frame
// never sees a half-updated configuration. PRESCALE and CTRL apply at once.
//
// Register map (wr_addr):
//   0      PERIOD
//   1      PRESCALE
//   2      CTRL   bit0 RUN, bit1 CENTER
//   3+i    DUTY[i]
//   other  ignored
//
// Optional feature macro: PWM_CENTER_ALIGN_EN
//   defined   -> CTRL.CENTER is stored and center-aligned (up/down) counting
//                is available.
//   undefined -> CTRL.CENTER is dropped, no direction state, edge mode only.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset, clears all state
//   ena          tile enable; low behaves exactly like RUN=0
//   wr_en        register write strobe (one write per cycle)
//   wr_addr      register address
//   wr_data      register write data
//   pwm_out      registered PWM outputs, one per channel
//   period_tick  one-cycle pulse aligned with the first output of a frame
// -----------------------------------------------------------------------------
module pwm_multichan #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_PRESCALE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_CTRL     = ADDR_W'(2);
    localparam int                DUTY_BASE     = 3;

    // Shadow (software-visible) registers
    logic [WIDTH-1:0] period_sh_q, period_sh_d;
    logic [WIDTH-1:0] prescale_q,  prescale_d;
    logic             run_q,       run_d;
    logic [WIDTH-1:0] duty_sh_q [CHANNELS];
    logic [WIDTH-1:0] duty_sh_d [CHANNELS];

    // Active copies used by the counter and comparators
    logic [WIDTH-1:0] period_act_q, period_act_d;
    logic [WIDTH-1:0] duty_act_q [CHANNELS];
    logic [WIDTH-1:0] duty_act_d [CHANNELS];

    // Timebase
    logic [WIDTH-1:0] presc_q, presc_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
`ifdef PWM_CENTER_ALIGN_EN
    logic             center_q,   center_d;
    logic             dir_down_q, dir_down_d;
`endif

    // Output stage
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                bnd_q, bnd_d;
    logic                tick_q, tick_d;

    logic running;
    logic presc_hit;
    logic boundary;
    logic restart;

    always_comb begin
        period_sh_d  = period_sh_q;
        prescale_d   = prescale_q;
        run_d        = run_q;
        duty_sh_d    = duty_sh_q;
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        presc_d      = presc_q;
        cnt_d        = cnt_q;
`ifdef PWM_CENTER_ALIGN_EN
        center_d     = center_q;
        dir_down_d   = dir_down_q;
`endif
        boundary     = 1'b0;
        restart      = 1'b0;
        running      = run_q & ena;
        // >= rather than == so that lowering PRESCALE below the current
        // prescaler value wraps at once instead of running round the range.
        presc_hit    = (presc_q >= prescale_q);

        // Register writes land in the shadow copies only.
        if (wr_en) begin
            if (wr_addr == ADDR_PERIOD) begin
                period_sh_d = wr_data;
            end
            if (wr_addr == ADDR_PRESCALE) begin
                prescale_d = wr_data;
            end
            if (wr_addr == ADDR_CTRL) begin
                run_d = wr_data[0];
`ifdef PWM_CENTER_ALIGN_EN
                center_d = wr_data[1];
                // Switching counting mode mid-run restarts the frame silently.
                restart  = running && (wr_data[1] != center_q);
`endif
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_addr == ADDR_W'(i + DUTY_BASE)) begin
                    duty_sh_d[i] = wr_data;
                end
            end
        end

        if (!running) begin
            // Stopped: timebase parked at 0/up, active copies track shadows.
            presc_d      = '0;
            cnt_d        = '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down_d   = 1'b0;
`endif
            period_act_d = period_sh_q;
            duty_act_d   = duty_sh_q;
        end else if (restart) begin
            presc_d    = '0;
            cnt_d      = '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down_d = 1'b0;
`endif
        end else begin
            presc_d = presc_hit ? '0 : presc_q + WIDTH'(1);
            if (presc_hit) begin
`ifdef PWM_CENTER_ALIGN_EN
                if (center_q) begin
                    // Up to PERIOD, hold it once while turning, down to 0,
                    // hold 0 once while turning: each value is seen twice.
                    if (!dir_down_q) begin
                        if (cnt_q == period_act_q) begin
                            dir_down_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + WIDTH'(1);
                        end
                    end else if (cnt_q == '0) begin
                        boundary   = 1'b1;
                        dir_down_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end
                end else
`endif
                begin
                    if (cnt_q == period_act_q) begin
                        boundary = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
            end
            // Reload uses the registered shadows, so a write in the boundary
            // cycle itself is deferred by one frame.
            if (boundary) begin
                period_act_d = period_sh_q;
                duty_act_d   = duty_sh_q;
            end
        end

        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = running && (cnt_q < duty_act_q[i]);
        end
        // Boundary is delayed two cycles so the tick lines up with the first
        // registered output of the new frame.
        bnd_d  = boundary;
        tick_d = running && bnd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_sh_q  <= '0;
            prescale_q   <= '0;
            run_q        <= 1'b0;
            period_act_q <= '0;
            presc_q      <= '0;
            cnt_q        <= '0;
`ifdef PWM_CENTER_ALIGN_EN
            center_q     <= 1'b0;
            dir_down_q   <= 1'b0;
`endif
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
            pwm_q  <= '0;
            bnd_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            period_sh_q  <= period_sh_d;
            prescale_q   <= prescale_d;
            run_q        <= run_d;
            period_act_q <= period_act_d;
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
`ifdef PWM_CENTER_ALIGN_EN
            center_q     <= center_d;
            dir_down_q   <= dir_down_d;
`endif
            duty_sh_q    <= duty_sh_d;
            duty_act_q   <= duty_act_d;
            pwm_q        <= pwm_d;
            bnd_q        <= bnd_d;
            tick_q       <= tick_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;

endmodule
